// File: rtl/store_write_buffer_if.sv
// Core-side store/load-forwarding signals and memory-side drain handshake of the store buffer.
// The buffer uses the slave modport; whatever drives the core and memory side uses master.
interface store_write_buffer_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Core store port
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              StoreStall;

    // Core load-forwarding lookup
    logic [ADDR_W-1:0] LoadAdr;
    logic              LoadHit;
    logic [DATA_W-1:0] LoadData;

    // Memory drain handshake
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    // Occupancy status
    logic              Empty;
    logic [CNT_W-1:0]  Count;

    modport master (
        output MemWrite, DataAdr, WriteData, LoadAdr, mem_ready,
        input  StoreStall, LoadHit, LoadData, mem_valid, mem_addr, mem_data, Empty, Count
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, LoadAdr, mem_ready,
        output StoreStall, LoadHit, LoadData, mem_valid, mem_addr, mem_data, Empty, Count
    );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store buffer between the core data port and a valid/ready data memory.
// Accepts one word store per cycle, drains in order, and forwards pending data to matching loads.
module store_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    store_write_buffer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WADR_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entries keep only the word address; byte offset is always zero on the bus.
    logic [WADR_W-1:0] addr_q [DEPTH];
    logic [WADR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty, enq, deq;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.DataAdr[1:0], bus.LoadAdr[1:0]};

    // Acceptance depends on registered occupancy only, so a full buffer stalls even while draining.
    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        enq   = bus.MemWrite & ~full;
        deq   = ~empty & bus.mem_ready;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq) begin
            addr_d[wr_ptr_q] = bus.DataAdr[ADDR_W-1:2];
            data_d[wr_ptr_q] = bus.WriteData;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Walk oldest to youngest so the last match, the youngest store, wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[fwd_idx] == bus.LoadAdr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        bus.StoreStall = bus.MemWrite & full;
        bus.mem_valid  = ~empty;
        bus.mem_addr   = empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
        bus.mem_data   = empty ? '0 : data_q[rd_ptr_q];
        bus.LoadHit    = fwd_hit;
        bus.LoadData   = fwd_data;
        bus.Empty      = empty;
        bus.Count      = count_q;
    end

    count_bounded: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);

    head_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.mem_valid && !bus.mem_ready) |=> ($stable(bus.mem_addr) && $stable(bus.mem_data)));
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios then random traffic, checked by a
// queue-based reference model and a monitor that compares every cycle.
module tb_store_write_buffer;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    store_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: the pending stores in acceptance order, oldest at index 0.
    entry_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    logic   done   = 1'b0;

    logic   pend_push = 1'b0;
    logic   pend_rst  = 1'b0;
    entry_t pend_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the store decided on last cycle takes effect at this edge.
    task automatic cycle(input logic rst, input logic mw, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] ladr, input logic rdy);
        @(posedge clk);
        if (pend_rst) exp_q.delete();
        else if (pend_push) exp_q.push_back(pend_e);
        #1;
        reset         = rst;
        bus.MemWrite  = mw;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.LoadAdr   = ladr;
        bus.mem_ready = rdy;
        pend_rst      = rst;
        pend_push     = mw && !rst && (exp_q.size() < DEPTH);
        pend_e.addr   = {adr[31:2], 2'b00};
        pend_e.data   = wd;
    endtask

    // Monitor: compare every visible output against the model, pop on each memory handshake.
    always @(negedge clk) begin
        int          n;
        logic        hit;
        logic [31:0] fd;
        if (!reset && !done) begin
            n   = exp_q.size();
            hit = 1'b0;
            fd  = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].addr[31:2] == bus.LoadAdr[31:2]) begin
                    hit = 1'b1;
                    fd  = exp_q[i].data;
                end
            end
            chk("count", 32'(bus.Count), n);
            chk("empty", 32'(bus.Empty), 32'(n == 0));
            chk("mem_valid", 32'(bus.mem_valid), 32'(n != 0));
            chk("store_stall", 32'(bus.StoreStall), 32'(bus.MemWrite && (n == DEPTH)));
            chk("load_hit", 32'(bus.LoadHit), 32'(hit));
            chk("load_data", bus.LoadData, fd);
            if (n == 0) begin
                chk("idle_addr", bus.mem_addr, 32'h0);
                chk("idle_data", bus.mem_data, 32'h0);
            end else begin
                chk("head_addr", bus.mem_addr, exp_q[0].addr);
                chk("head_data", bus.mem_data, exp_q[0].data);
            end
            if (bus.mem_valid && bus.mem_ready && n != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.LoadAdr   = '0;
        bus.mem_ready = 1'b0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Reset state
        cycle(0, 0, 0, 0, 32'h60, 0);
        @(negedge clk);
        chk("rst_empty", 32'(bus.Empty), 1);
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_valid", 32'(bus.mem_valid), 0);
        chk("rst_hit", 32'(bus.LoadHit), 0);

        // Fill with memory stalled; fifth store must be rejected
        for (int k = 0; k < 4; k++) cycle(0, 1, 32'h60 + 32'(4 * k), 32'(k + 1), 0, 0);
        cycle(0, 1, 32'h70, 5, 0, 0);
        @(negedge clk);
        chk("t1_stall", 32'(bus.StoreStall), 1);
        chk("t1_count", 32'(bus.Count), 4);
        cycle(0, 0, 0, 0, 32'h70, 0);
        @(negedge clk);
        chk("t1_no70", 32'(bus.LoadHit), 0);

        // Drain in order
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("t2_addr", bus.mem_addr, 32'h60 + 32'(4 * k));
            chk("t2_data", bus.mem_data, 32'(k + 1));
        end
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_empty", 32'(bus.Empty), 1);
        chk("t2_valid", 32'(bus.mem_valid), 0);

        // Steady enqueue/dequeue with pointer wrap
        cycle(0, 1, 32'h100, 32'hA0, 0, 0);
        cycle(0, 1, 32'h104, 32'hA1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1, 32'h108 + 32'(4 * k), 32'hA2 + 32'(k), 0, 1);
            @(negedge clk);
            chk("t3_count", 32'(bus.Count), 2);
            chk("t3_head", bus.mem_data, 32'hA0 + 32'(k));
        end
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Forwarding: youngest wins, same-cycle store not yet visible
        cycle(0, 1, 32'h64, 7, 0, 0);
        cycle(0, 1, 32'h64, 25, 32'h66, 0);
        @(negedge clk);
        chk("t4_fwd_old", bus.LoadData, 7);
        cycle(0, 0, 0, 0, 32'h66, 0);
        @(negedge clk);
        chk("t4_hit", 32'(bus.LoadHit), 1);
        chk("t4_data", bus.LoadData, 25);
        cycle(0, 0, 0, 0, 32'h68, 0);
        @(negedge clk);
        chk("t4_miss", 32'(bus.LoadHit), 0);
        chk("t4_miss_data", bus.LoadData, 0);

        // Full buffer draining still stalls; retry accepted next cycle
        cycle(0, 1, 32'h300, 32'hD1, 0, 0);
        cycle(0, 1, 32'h304, 32'hD2, 0, 0);
        cycle(0, 1, 32'h308, 32'h33, 0, 1);
        @(negedge clk);
        chk("t5_stall", 32'(bus.StoreStall), 1);
        cycle(0, 1, 32'h308, 32'h33, 0, 0);
        @(negedge clk);
        chk("t5_count3", 32'(bus.Count), 3);
        chk("t5_accept", 32'(bus.StoreStall), 0);
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_count4", 32'(bus.Count), 4);

        // Reset with pending stores discards them
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t6_pre", 32'(bus.Count), 3);
        cycle(0, 0, 0, 0, 32'h304, 1);
        @(negedge clk);
        chk("t6_count", 32'(bus.Count), 0);
        chk("t6_valid", 32'(bus.mem_valid), 0);
        chk("t6_hit", 32'(bus.LoadHit), 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1);

        // Random traffic over a small address pool to provoke hits and full stalls
        for (int i = 0; i < 1500; i++) begin
            automatic logic [31:0] a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            automatic logic [31:0] l = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, a, $urandom, l,
                  $urandom_range(0, 9) < 4);
        end
        for (int k = 0; k < DEPTH + 2; k++) cycle(0, 0, 0, 0, 0, 1);

        @(negedge clk);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
